// File: rtl/clause_status_scanner_pkg.sv
// rtl/clause_status_scanner_pkg.sv - literal codes, clause status and scanner state encodings
package clause_status_scanner_pkg;

    localparam logic [1:0] LIT_EMPTY = 2'b00;
    localparam logic [1:0] LIT_FALSE = 2'b01;
    localparam logic [1:0] LIT_TRUE  = 2'b10;
    localparam logic [1:0] LIT_UNASG = 2'b11;

    typedef enum logic [1:0] {
        SAT      = 2'd0,
        UNIT     = 2'd1,
        UNDEF    = 2'd2,
        CONFLICT = 2'd3
    } clause_status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // A single-literal clause still needs a one-bit slot field
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clause_status_scanner_if.sv
// rtl/clause_status_scanner_if.sv - start/done handshake, clause memory port and result bus
// STAT_COUNT_EN adds the per-run status counters to the bundle.
interface clause_status_scanner_if #(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_LITS    = 3
) ();
    localparam int ADDR_W = $clog2(NUM_CLAUSES);
    localparam int SLOT_W = clause_status_scanner_pkg::min1_clog2(NUM_LITS);

    logic                  start;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [2*NUM_LITS-1:0] mem_rdata;
    logic                  conflict;
    logic [ADDR_W-1:0]     conflict_idx;
    logic                  unit_found;
    logic [ADDR_W-1:0]     unit_idx;
    logic [SLOT_W-1:0]     unit_slot;

`ifdef STAT_COUNT_EN
    localparam int CNT_W = $clog2(NUM_CLAUSES + 1);
    logic [CNT_W-1:0] sat_cnt;
    logic [CNT_W-1:0] unit_cnt;
    logic [CNT_W-1:0] undef_cnt;

    modport master (
        output start, mem_rdata,
        input  done, mem_rd_en, mem_addr, conflict, conflict_idx,
               unit_found, unit_idx, unit_slot, sat_cnt, unit_cnt, undef_cnt
    );
    modport slave (
        input  start, mem_rdata,
        output done, mem_rd_en, mem_addr, conflict, conflict_idx,
               unit_found, unit_idx, unit_slot, sat_cnt, unit_cnt, undef_cnt
    );
`else
    modport master (
        output start, mem_rdata,
        input  done, mem_rd_en, mem_addr, conflict, conflict_idx,
               unit_found, unit_idx, unit_slot
    );
    modport slave (
        input  start, mem_rdata,
        output done, mem_rd_en, mem_addr, conflict, conflict_idx,
               unit_found, unit_idx, unit_slot
    );
`endif
endinterface

// File: rtl/clause_status_scanner_eval.sv
// rtl/clause_status_scanner_eval.sv - combinational classifier for one clause word
import clause_status_scanner_pkg::*;

module clause_status_eval #(
    parameter int NUM_LITS = 3,
    parameter int SLOT_W   = min1_clog2(NUM_LITS)
) (
    input  logic [2*NUM_LITS-1:0] word_i,
    output clause_status_t        status_o,
    output logic [SLOT_W-1:0]     unit_slot_o
);
    localparam int CNT_W = $clog2(NUM_LITS + 1);

    logic             any_true;
    logic [CNT_W-1:0] n_unasg;
    logic [1:0]       lit;

    always_comb begin
        any_true    = 1'b0;
        n_unasg     = '0;
        unit_slot_o = '0;
        lit         = LIT_EMPTY;
        for (int i = 0; i < NUM_LITS; i++) begin
            lit = word_i[2*i +: 2];
            if (lit == LIT_TRUE) any_true = 1'b1;
            if (lit == LIT_UNASG) begin
                n_unasg     = n_unasg + CNT_W'(1);
                unit_slot_o = SLOT_W'(i);
            end
        end
        // An all-empty word has no unassigned literal and so lands in CONFLICT
        if (any_true)                  status_o = SAT;
        else if (n_unasg == CNT_W'(0)) status_o = CONFLICT;
        else if (n_unasg == CNT_W'(1)) status_o = UNIT;
        else                           status_o = UNDEF;
    end

endmodule

// File: rtl/clause_status_scanner.sv
// rtl/clause_status_scanner.sv - start/done responder scanning and classifying all clauses
// STAT_COUNT_EN adds sat/unit/undef counters covering the clauses evaluated this run.
import clause_status_scanner_pkg::*;

module clause_status_scanner #(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_LITS    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    clause_status_scanner_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_CLAUSES);
    localparam int SLOT_W = min1_clog2(NUM_LITS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CLAUSES - 1);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, eval_idx_q;
    logic              rd_valid_q, rd_en;
    logic              conflict_q, conflict_d, unit_found_q, unit_found_d;
    logic [ADDR_W-1:0] conflict_idx_q, conflict_idx_d, unit_idx_q, unit_idx_d;
    logic [SLOT_W-1:0] unit_slot_q, unit_slot_d;
    clause_status_t    status;
    logic [SLOT_W-1:0] slot;
    logic              eval_en;

    clause_status_eval #(.NUM_LITS(NUM_LITS), .SLOT_W(SLOT_W)) u_eval (
        .word_i      (bus.mem_rdata),
        .status_o    (status),
        .unit_slot_o (slot)
    );

    // Word on mem_rdata belongs to the previous cycle's read; ignored outside an active run
    assign eval_en = rd_valid_q && bus.start && (state_q == SCAN || state_q == DRAIN);

`ifdef STAT_COUNT_EN
    localparam int CNT_W = $clog2(NUM_CLAUSES + 1);
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d, unit_cnt_q, unit_cnt_d, undef_cnt_q, undef_cnt_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_en          = 1'b0;
        conflict_d     = conflict_q;
        conflict_idx_d = conflict_idx_q;
        unit_found_d   = unit_found_q;
        unit_idx_d     = unit_idx_q;
        unit_slot_d    = unit_slot_q;
`ifdef STAT_COUNT_EN
        sat_cnt_d      = sat_cnt_q;
        unit_cnt_d     = unit_cnt_q;
        undef_cnt_d    = undef_cnt_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                state_d        = SCAN;
                cnt_d          = '0;
                conflict_d     = 1'b0;
                conflict_idx_d = '0;
                unit_found_d   = 1'b0;
                unit_idx_d     = '0;
                unit_slot_d    = '0;
`ifdef STAT_COUNT_EN
                sat_cnt_d      = '0;
                unit_cnt_d     = '0;
                undef_cnt_d    = '0;
`endif
            end
            SCAN: begin
                rd_en = 1'b1;
                cnt_d = cnt_q + ADDR_W'(1);
                if (!bus.start)                         state_d = IDLE;
                else if (eval_en && status == CONFLICT) state_d = DONE;
                else if (cnt_q == LAST)                 state_d = DRAIN;
            end
            DRAIN:   state_d = bus.start ? DONE : IDLE;
            DONE:    if (!bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (eval_en) begin
            if (status == CONFLICT) begin
                conflict_d     = 1'b1;
                conflict_idx_d = eval_idx_q;
            end else if (status == UNIT && !unit_found_q) begin
                unit_found_d = 1'b1;
                unit_idx_d   = eval_idx_q;
                unit_slot_d  = slot;
            end
`ifdef STAT_COUNT_EN
            case (status)
                SAT:     sat_cnt_d   = sat_cnt_q + CNT_W'(1);
                UNIT:    unit_cnt_d  = unit_cnt_q + CNT_W'(1);
                UNDEF:   undef_cnt_d = undef_cnt_q + CNT_W'(1);
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            eval_idx_q     <= '0;
            rd_valid_q     <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
            unit_found_q   <= 1'b0;
            unit_idx_q     <= '0;
            unit_slot_q    <= '0;
`ifdef STAT_COUNT_EN
            sat_cnt_q      <= '0;
            unit_cnt_q     <= '0;
            undef_cnt_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            eval_idx_q     <= cnt_q;
            rd_valid_q     <= rd_en;
            conflict_q     <= conflict_d;
            conflict_idx_q <= conflict_idx_d;
            unit_found_q   <= unit_found_d;
            unit_idx_q     <= unit_idx_d;
            unit_slot_q    <= unit_slot_d;
`ifdef STAT_COUNT_EN
            sat_cnt_q      <= sat_cnt_d;
            unit_cnt_q     <= unit_cnt_d;
            undef_cnt_q    <= undef_cnt_d;
`endif
        end
    end

    assign bus.done         = (state_q == DONE);
    assign bus.mem_rd_en    = rd_en;
    assign bus.mem_addr     = rd_en ? cnt_q : '0;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_idx = conflict_idx_q;
    assign bus.unit_found   = unit_found_q;
    assign bus.unit_idx     = unit_idx_q;
    assign bus.unit_slot    = unit_slot_q;
`ifdef STAT_COUNT_EN
    assign bus.sat_cnt      = sat_cnt_q;
    assign bus.unit_cnt     = unit_cnt_q;
    assign bus.undef_cnt    = undef_cnt_q;
`endif

endmodule
